// File: rtl/game_turn_if.sv
// Handshake bundle between the turn controller, the enter buttons and the
// code/guess datapath.
interface game_turn_if #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned MAX_GUESSES = 8
);
    localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
    localparam int unsigned GW = $clog2(MAX_GUESSES + 1);

    logic [NUM_PLAYERS-1:0] enter;
    logic                   code_valid;
    logic                   guess_valid;
    logic                   guess_correct;
    logic                   new_game;
    logic                   abort;
    logic [PW-1:0]          maker_id;
    logic [PW-1:0]          active_p;
    logic                   take_code;
    logic                   take_guess;
    logic                   started;
    logic                   clear_n;
    logic [GW-1:0]          guess_cnt;
    logic                   game_over;
    logic                   guesser_won;

    modport master (
        output enter, code_valid, guess_valid, guess_correct, new_game, abort,
        input  maker_id, active_p, take_code, take_guess, started, clear_n,
               guess_cnt, game_over, guesser_won
    );

    modport slave (
        input  enter, code_valid, guess_valid, guess_correct, new_game, abort,
        output maker_id, active_p, take_code, take_guess, started, clear_n,
               guess_cnt, game_over, guesser_won
    );
endinterface

// File: rtl/game_turn_ctrl.sv
// Mastermind start/turn controller: picks the code maker, sequences code
// entry, rotates guessers and declares the result.
module game_turn_ctrl #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned MAX_GUESSES = 8
) (
    input  logic       clk,
    input  logic       reset,
    game_turn_if.slave bus
);
    localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
    localparam int unsigned GW = $clog2(MAX_GUESSES + 1);

    typedef enum logic [1:0] {IDLE, CODE, GUESS, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] maker_q, maker_d;
    logic [PW-1:0] active_q, active_d;
    logic [GW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          won_q, won_d;
    logic          take_code_q, take_code_d;
    logic          take_guess_q, take_guess_d;
    logic          started_q, started_d;
    logic          clear_n_q, clear_n_d;
    logic          game_over_q, game_over_d;
    int unsigned   hot_cnt;
    logic [PW-1:0] hot_idx;

    // Next player after cur in cyclic order, skipping the code maker.
    function automatic logic [PW-1:0] next_player(input logic [PW-1:0] cur,
                                                  input logic [PW-1:0] mk);
        logic [PW-1:0] nxt;
        logic          found;
        int unsigned   j;
        nxt   = cur;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 1; k < NUM_PLAYERS; k++) begin
            j = (32'(cur) + k) % NUM_PLAYERS;
            if (!found && (PW'(j) != mk)) begin
                nxt   = PW'(j);
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

    always_comb begin
        hot_cnt = 0;
        hot_idx = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (bus.enter[i]) begin
                hot_cnt = hot_cnt + 1;
                hot_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        maker_d  = maker_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        won_d    = won_q;
        cnt_inc  = (cnt_q == GW'(MAX_GUESSES)) ? cnt_q : cnt_q + GW'(1);

        if (bus.abort) begin
            state_d  = IDLE;
            active_d = '0;
            cnt_d    = '0;
            won_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hot_cnt == 1) begin
                        maker_d  = hot_idx;
                        active_d = hot_idx;
                        state_d  = CODE;
                    end
                end
                CODE: begin
                    if (bus.code_valid) begin
                        active_d = next_player(maker_q, maker_q);
                        cnt_d    = '0;
                        state_d  = GUESS;
                    end
                end
                GUESS: begin
                    if (bus.guess_valid) begin
                        cnt_d = cnt_inc;
                        if (bus.guess_correct) begin
                            won_d   = 1'b1;
                            state_d = DONE;
                        end else if (cnt_inc == GW'(MAX_GUESSES)) begin
                            won_d   = 1'b0;
                            state_d = DONE;
                        end else begin
                            active_d = next_player(active_q, maker_q);
                        end
                    end
                end
                DONE: begin
                    if (bus.new_game) begin
                        active_d = '0;
                        cnt_d    = '0;
                        won_d    = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Status flags are registered from the next state.
        take_code_d  = (state_d == CODE);
        take_guess_d = (state_d == GUESS);
        started_d    = (state_d != IDLE);
        clear_n_d    = (state_d != IDLE);
        game_over_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            maker_q      <= '0;
            active_q     <= '0;
            cnt_q        <= '0;
            won_q        <= 1'b0;
            take_code_q  <= 1'b0;
            take_guess_q <= 1'b0;
            started_q    <= 1'b0;
            clear_n_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            maker_q      <= maker_d;
            active_q     <= active_d;
            cnt_q        <= cnt_d;
            won_q        <= won_d;
            take_code_q  <= take_code_d;
            take_guess_q <= take_guess_d;
            started_q    <= started_d;
            clear_n_q    <= clear_n_d;
            game_over_q  <= game_over_d;
        end
    end

    assign bus.maker_id    = maker_q;
    assign bus.active_p    = active_q;
    assign bus.guess_cnt   = cnt_q;
    assign bus.guesser_won = won_q;
    assign bus.take_code   = take_code_q;
    assign bus.take_guess  = take_guess_q;
    assign bus.started     = started_q;
    assign bus.clear_n     = clear_n_q;
    assign bus.game_over   = game_over_q;
endmodule

// File: tb/tb_game_turn_ctrl.sv
// Self-checking bench for game_turn_ctrl: reset sequence, directed vector
// table, then random traffic against a rotation-list reference model.
module tb_game_turn_ctrl;
    localparam int unsigned NP = 4;
    localparam int unsigned MG = 6;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    game_turn_if #(.NUM_PLAYERS(NP), .MAX_GUESSES(MG)) bus ();

    game_turn_ctrl #(.NUM_PLAYERS(NP), .MAX_GUESSES(MG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ph: 0 idle, 1 code entry, 2 guessing, 3 done; act/mk of -1 = don't care
    typedef struct {
        logic [3:0] en;
        bit cv, gv, gc, ng, ab;
        int ph, cnt, act, mk;
        bit won;
    } vec_t;
    vec_t vecs[$];

    // reference model: guessers held as an explicit rotation list
    int m_ph, m_maker, m_pos, m_cnt;
    bit m_won;
    int m_list[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input int ph, input int cnt,
                              input int act, input int mk, input bit won);
        chk({name, ".started"},    int'(bus.started),    int'(ph != 0));
        chk({name, ".clear_n"},    int'(bus.clear_n),    int'(ph != 0));
        chk({name, ".take_code"},  int'(bus.take_code),  int'(ph == 1));
        chk({name, ".take_guess"}, int'(bus.take_guess), int'(ph == 2));
        chk({name, ".game_over"},  int'(bus.game_over),  int'(ph == 3));
        chk({name, ".won"},        int'(bus.guesser_won), int'(won));
        chk({name, ".cnt"},        int'(bus.guess_cnt),  cnt);
        if (act >= 0) chk({name, ".active_p"}, int'(bus.active_p), act);
        if (mk >= 0)  chk({name, ".maker_id"}, int'(bus.maker_id), mk);
    endtask

    task automatic apply(input logic [3:0] en, input bit cv, input bit gv,
                         input bit gc, input bit ng, input bit ab);
        bus.enter         = en;
        bus.code_valid    = cv;
        bus.guess_valid   = gv;
        bus.guess_correct = gc;
        bus.new_game      = ng;
        bus.abort         = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] en, input bit cv, input bit gv,
                       input bit gc, input bit ng, input bit ab,
                       input int ph, input int cnt, input int act,
                       input int mk, input bit won);
        vec_t v;
        v.en = en; v.cv = cv; v.gv = gv; v.gc = gc; v.ng = ng; v.ab = ab;
        v.ph = ph; v.cnt = cnt; v.act = act; v.mk = mk; v.won = won;
        vecs.push_back(v);
    endtask

    task automatic model_step(input logic [3:0] en, input bit cv, input bit gv,
                              input bit gc, input bit ng, input bit ab);
        if (ab) begin
            m_ph = 0; m_cnt = 0; m_won = 0;
        end else if (m_ph == 0) begin
            if ($countones(en) == 1) begin
                m_maker = $clog2(en);
                m_ph    = 1;
            end
        end else if (m_ph == 1) begin
            if (cv) begin
                m_list.delete();
                for (int k = 1; k < int'(NP); k++) m_list.push_back((m_maker + k) % int'(NP));
                m_pos = 0; m_cnt = 0; m_ph = 2;
            end
        end else if (m_ph == 2) begin
            if (gv) begin
                m_cnt = m_cnt + 1;
                if (gc) begin
                    m_won = 1; m_ph = 3;
                end else if (m_cnt == int'(MG)) begin
                    m_won = 0; m_ph = 3;
                end else begin
                    m_pos = (m_pos + 1) % (int'(NP) - 1);
                end
            end
        end else if (ng) begin
            m_ph = 0; m_cnt = 0; m_won = 0;
        end
    endtask

    initial begin
        logic [3:0] r_en;
        bit r_cv, r_gv, r_gc, r_ng, r_ab;
        int e_act, e_mk, sel;
        checks = 0; failures = 0;
        reset = 1'b0;
        bus.enter = '0; bus.code_valid = 0; bus.guess_valid = 0;
        bus.guess_correct = 0; bus.new_game = 0; bus.abort = 0;

        #3;
        check_outs("rst0", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        apply(4'b0001, 0, 0, 0, 0, 0); check_outs("rst_sel", 1, 0, 0, 0, 0);
        apply(4'b0000, 1, 0, 0, 0, 0); check_outs("rst_code", 2, 0, 1, 0, 0);
        apply(4'b0000, 0, 1, 0, 0, 0); check_outs("rst_g1", 2, 1, 2, 0, 0);
        #2 reset = 1'b0;
        #1 check_outs("rst_mid", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        apply(4'b0001, 0, 0, 0, 0, 0); check_outs("rst_resel", 1, 0, 0, 0, 0);

        //   en       cv gv gc ng ab  ph cnt act mk won
        add(4'b0000, 0, 0, 0, 0, 1,  0, 0, -1, -1, 0);
        add(4'b0011, 0, 0, 0, 0, 0,  0, 0, -1, -1, 0);
        add(4'b0011, 0, 0, 0, 0, 0,  0, 0, -1, -1, 0);
        add(4'b0000, 0, 0, 0, 0, 0,  0, 0, -1, -1, 0);
        add(4'b0000, 1, 0, 0, 0, 0,  0, 0, -1, -1, 0);
        add(4'b0010, 0, 0, 0, 0, 0,  1, 0,  1,  1, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  1, 0,  1,  1, 0);
        add(4'b0000, 1, 0, 0, 0, 0,  2, 0,  2,  1, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 1,  3,  1, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 2,  0,  1, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 3,  2,  1, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 4,  3,  1, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 5,  0,  1, 0);
        add(4'b0000, 0, 0, 0, 0, 0,  2, 5,  0,  1, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  3, 6,  0,  1, 0);
        add(4'b0000, 0, 1, 1, 0, 0,  3, 6,  0,  1, 0);
        add(4'b0000, 0, 0, 0, 1, 0,  0, 0, -1, -1, 0);
        add(4'b1000, 0, 0, 0, 0, 0,  1, 0,  3,  3, 0);
        add(4'b0000, 0, 0, 0, 0, 1,  0, 0, -1, -1, 0);
        add(4'b0001, 0, 0, 0, 0, 0,  1, 0,  0,  0, 0);
        add(4'b0000, 1, 0, 0, 0, 0,  2, 0,  1,  0, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 1,  2,  0, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 2,  3,  0, 0);
        add(4'b0000, 0, 0, 0, 0, 1,  0, 0, -1, -1, 0);
        add(4'b0100, 0, 0, 0, 0, 0,  1, 0,  2,  2, 0);
        add(4'b0000, 1, 0, 0, 0, 0,  2, 0,  3,  2, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 1,  0,  2, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 2,  1,  2, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 3,  3,  2, 0);
        add(4'b0000, 0, 1, 1, 0, 0,  3, 4,  3,  2, 1);
        add(4'b0001, 1, 0, 0, 0, 0,  3, 4,  3,  2, 1);
        add(4'b0000, 0, 0, 0, 0, 1,  0, 0, -1, -1, 0);
        add(4'b0001, 0, 0, 0, 0, 0,  1, 0,  0,  0, 0);
        add(4'b0000, 1, 0, 0, 0, 0,  2, 0,  1,  0, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 1,  2,  0, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 2,  3,  0, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 3,  1,  0, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 4,  2,  0, 0);
        add(4'b0000, 0, 1, 0, 0, 0,  2, 5,  3,  0, 0);
        add(4'b0000, 0, 1, 1, 0, 0,  3, 6,  3,  0, 1);
        add(4'b0000, 0, 0, 0, 1, 0,  0, 0, -1, -1, 0);
        add(4'b0010, 0, 0, 0, 0, 1,  0, 0, -1, -1, 0);
        add(4'b0010, 0, 0, 0, 0, 0,  1, 0,  1,  1, 0);
        add(4'b0000, 0, 0, 0, 0, 1,  0, 0, -1, -1, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].cv, vecs[i].gv, vecs[i].gc, vecs[i].ng, vecs[i].ab);
            check_outs($sformatf("vec%0d", i), vecs[i].ph, vecs[i].cnt,
                       vecs[i].act, vecs[i].mk, vecs[i].won);
        end

        m_ph = 0; m_maker = 0; m_pos = 0; m_cnt = 0; m_won = 0;
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      r_en = 4'b0000;
            else if (sel < 8) r_en = 4'(4'b0001 << $urandom_range(0, 3));
            else              r_en = 4'($urandom_range(0, 15));
            r_cv = ($urandom_range(0, 3) == 0);
            r_gv = ($urandom_range(0, 2) == 0);
            r_gc = ($urandom_range(0, 3) == 0);
            r_ng = ($urandom_range(0, 5) == 0);
            r_ab = ($urandom_range(0, 40) == 0);
            model_step(r_en, r_cv, r_gv, r_gc, r_ng, r_ab);
            apply(r_en, r_cv, r_gv, r_gc, r_ng, r_ab);
            e_mk  = (m_ph == 0) ? -1 : m_maker;
            e_act = (m_ph == 0) ? -1 : (m_ph == 1) ? m_maker : m_list[m_pos];
            check_outs($sformatf("rnd%0d", i), m_ph, m_cnt, e_act, e_mk, m_won);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
